// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit in front of a word-wide synchronous data memory.
// Build option LSU_SUBWORD_EN adds byte/halfword loads and read-modify-write sub-word stores.
module lsu #(
  parameter int DM_AW = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [DM_AW-1:0]  dm_addr,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  output logic [2:0]        dbg_state
);

  // Handshake: req is taken on a rising edge while busy=0 (no queueing while busy);
  // each accepted request ends in exactly one done pulse, qualified by err, unless rst aborts it.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LDRSP = 3'd2,
`ifdef LSU_SUBWORD_EN
    MOD   = 3'd3,
`endif
    WR    = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        bad;
  logic [31:0] load_val;

`ifdef LSU_SUBWORD_EN
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        sign_q;
  logic        we_q;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] merged;
  logic        unused;

  assign unused = &{1'b0, addr[31:DM_AW+2]};
  assign bad = (size == 2'b11) ||
               (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00);

  // Little-endian lane select for loads; stores overwrite only the addressed lane(s).
  always_comb begin
    byte_v   = dm_rdata[{off_q, 3'b000} +: 8];
    half_v   = dm_rdata[{off_q[1], 4'b0000} +: 16];
    load_val = dm_rdata;
    merged   = dm_rdata;
    case (size_q)
      2'b00: begin
        load_val = {{24{sign_q & byte_v[7]}}, byte_v};
        merged[{off_q, 3'b000} +: 8] = dm_wdata[7:0];
      end
      2'b01: begin
        load_val = {{16{sign_q & half_v[15]}}, half_v};
        merged[{off_q[1], 4'b0000} +: 16] = dm_wdata[15:0];
      end
      default: ;
    endcase
  end
`else
  logic unused;

  assign unused   = &{1'b0, addr[31:DM_AW+2], sign_ext};
  assign bad      = (size != 2'b10) || (addr[1:0] != 2'b00);
  assign load_val = dm_rdata;
`endif

  assign busy      = (state != IDLE);
  assign dm_rd     = (state == RD);
  assign dm_wr     = (state == WR);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req && !bad) begin
          if (!we) state_nxt = RD;
`ifdef LSU_SUBWORD_EN
          else if (size != 2'b10) state_nxt = RD;
`endif
          else state_nxt = WR;
        end
      end
`ifdef LSU_SUBWORD_EN
      RD:      state_nxt = we_q ? MOD : LDRSP;
      MOD:     state_nxt = WR;
`else
      RD:      state_nxt = LDRSP;
`endif
      LDRSP:   state_nxt = IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'h0;
      dm_wdata <= 32'h0;
      dm_addr  <= '0;
`ifdef LSU_SUBWORD_EN
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      sign_q   <= 1'b0;
      we_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            // dm_wdata holds the raw store data until WR (or until MOD merges it).
            dm_addr  <= addr[DM_AW+1:2];
            dm_wdata <= wdata;
`ifdef LSU_SUBWORD_EN
            size_q   <= size;
            off_q    <= addr[1:0];
            sign_q   <= sign_ext;
            we_q     <= we;
`endif
            if (bad) begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        LDRSP: begin
          rdata <= load_val;
          done  <= 1'b1;
        end
`ifdef LSU_SUBWORD_EN
        MOD: dm_wdata <= merged;
`endif
        WR:      done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed checks of lsu against a bench-side synchronous word memory.
// Sub-word cases are compiled in when LSU_SUBWORD_EN is defined.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [6:0]  dm_addr;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [2:0]  dbg_state;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:127];

  // clock / reset
  always #5 clk = ~clk;

  lsu #(.DM_AW(7)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dbg_state(dbg_state)
  );

  // synchronous word memory: read data valid the cycle after dm_rd is sampled
  always @(posedge clk) begin
    if (dm_rd) dm_rdata <= mem[dm_addr];
    if (dm_wr) mem[dm_addr] <= dm_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; drives one request, then waits (bounded) for done.
  task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                      input logic exp_err, input int exp_rd, input int exp_wr);
    int   lat;
    int   nrd;
    int   nwr;
    logic e;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    lat = 0; nrd = 0; nwr = 0; e = 1'bx;
    for (int n = 1; n <= 12; n++) begin
      if (dm_rd) nrd++;
      if (dm_wr) nwr++;
      if (done) begin
        lat = n;
        e = err;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    chk({tag, "_nrd"}, 32'(nrd), 32'(exp_rd));
    chk({tag, "_nwr"}, 32'(nwr), 32'(exp_wr));
  endtask

  initial begin
    int lat;
    int nrd;
    int aborts;
    req = 1'b0; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_dm_addr", {25'b0, dm_addr}, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    chk("rst_strobes", {30'b0, dm_rd, dm_wr}, 32'h0);
    chk("rst_state", {29'b0, dbg_state}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // word store then word load (back-to-back: load issued in the done cycle)
    xfer("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 0, 1);
    chk("st_w_mem", mem[4], 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    xfer("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 1'b0, 1, 0);
    chk("ld_w_data", rdata, exp_q.pop_front());

    // misaligned / reserved accesses: err at E0+1, no memory traffic, rdata kept
    xfer("ld_w_mis", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1, 1'b1, 0, 0);
    xfer("ld_h_mis", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1, 1'b1, 0, 0);
    chk("ld_h_mis_rdata", rdata, 32'hDEADBEEF);
    xfer("st_rsv", 1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678, 1, 1'b1, 0, 0);
    chk("st_rsv_mem", mem[8], 32'h0);

    // upper address bits wrap
    xfer("st_wrap", 1'b1, 2'b10, 1'b0, 32'hFFFFFE04, 32'hCAFEF00D, 2, 1'b0, 0, 1);
    chk("st_wrap_mem", mem[1], 32'hCAFEF00D);
    exp_q.push_back(32'hCAFEF00D);
    xfer("ld_wrap", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 3, 1'b0, 1, 0);
    chk("ld_wrap_data", rdata, exp_q.pop_front());

    // req held high while busy must not queue a second access
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
    lat = 0; nrd = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (dm_rd) nrd++;
      if (done) begin
        lat = n;
        req = 1'b0;
        break;
      end
    end
    req = 1'b0;
    chk("hold_lat", 32'(lat), 32'd3);
    chk("hold_nrd", 32'(nrd), 32'd1);
    chk("hold_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("hold_idle", {31'b0, busy}, 32'h0);

`ifdef LSU_SUBWORD_EN
    mem[4] = 32'h11223344;
    xfer("st_b", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 4, 1'b0, 1, 1);
    chk("st_b_mem", mem[4], 32'h11AA3344);
    mem[5] = 32'hAABBCCDD;
    xfer("st_h", 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234, 4, 1'b0, 1, 1);
    chk("st_h_mem", mem[5], 32'h1234CCDD);
    mem[4] = 32'h8000F0FF;
    exp_q.push_back(32'hFFFFFFFF);
    xfer("ld_b_s", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 3, 1'b0, 1, 0);
    chk("ld_b_s_data", rdata, exp_q.pop_front());
    exp_q.push_back(32'h00008000);
    xfer("ld_h_z", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 3, 1'b0, 1, 0);
    chk("ld_h_z_data", rdata, exp_q.pop_front());
    exp_q.push_back(32'hFFFFFF80);
    xfer("ld_b3_s", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 3, 1'b0, 1, 0);
    chk("ld_b3_s_data", rdata, exp_q.pop_front());
    exp_q.push_back(32'hFFFFF0FF);
    xfer("ld_h0_s", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 3, 1'b0, 1, 0);
    chk("ld_h0_s_data", rdata, exp_q.pop_front());

    // reset while in MOD of a byte store
    mem[4] = 32'h11223344;
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h10; wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("mod_reached", {29'b0, dbg_state}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mod_rst_busy", {31'b0, busy}, 32'h0);
    aborts = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done || dm_wr) aborts++;
    end
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done || dm_wr) aborts++;
    end
    chk("mod_rst_quiet", 32'(aborts), 32'h0);
    chk("mod_rst_mem", mem[4], 32'h11223344);
`else
    xfer("st_b_off", 1'b1, 2'b00, 1'b0, 32'h10, 32'h000000AA, 1, 1'b1, 0, 0);
    chk("st_b_off_mem", mem[4], 32'hDEADBEEF);
    xfer("ld_h_off", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1, 1'b1, 0, 0);
    chk("ld_h_off_rdata", rdata, 32'hDEADBEEF);
`endif

    // reset while in WR of a word store: write suppressed, no done, rdata cleared
    mem[6] = 32'h01234567;
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h18; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    req = 1'b0;
    chk("wr_reached", {31'b0, dm_wr}, 32'h1);
    rst = 1'b1;
    #1;
    chk("wr_rst_strobe", {30'b0, busy, dm_wr}, 32'h0);
    aborts = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done || dm_wr) aborts++;
    end
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done || dm_wr) aborts++;
    end
    chk("wr_rst_quiet", 32'(aborts), 32'h0);
    chk("wr_rst_mem", mem[6], 32'h01234567);
    chk("wr_rst_rdata", rdata, 32'h0);

    // unit still usable after the abort
    exp_q.push_back(32'h01234567);
    xfer("ld_after", 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 3, 1'b0, 1, 0);
    chk("ld_after_data", rdata, exp_q.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
